// File: rtl/ppu_packer.sv
// Packs the PPU int8 output stream into 32-bit little-endian words and queues
// them in a small FIFO feeding the GLB valid/ready write port.
module ppu_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [15:0]          num_bytes,
  input  logic                 i_en,
  input  logic [7:0]           data_in,
  output logic                 in_ready,
  output logic                 glb_wvalid,
  input  logic                 glb_wready,
  output logic [ADDR_BITS-1:0] glb_waddr,
  output logic [31:0]          glb_wdata,
  output logic [3:0]           glb_wstrb,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Strobe mask covering lanes 0..lane of the word being pushed.
  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    logic [3:0] s;
    case (lane)
      2'd0:    s = 4'b0001;
      2'd1:    s = 4'b0011;
      2'd2:    s = 4'b0111;
      2'd3:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Word address wraps modulo 2^ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] word_addr(input logic [ADDR_BITS-1:0] base,
                                                      input logic [15:0]          idx);
    return base + ADDR_BITS'({idx, 2'b00});
  endfunction

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   base_q, base_d;
  logic [15:0]            num_q, num_d;
  logic [15:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]            word_cnt_q, word_cnt_d;
  logic [1:0]             lane_q, lane_d;
  logic [23:0]            pack_q, pack_d;
  logic                   overflow_q, overflow_d;
  logic                   done_q, done_d;

  logic [31:0]            fifo_data_q [FIFO_DEPTH];
  logic [3:0]             fifo_strb_q [FIFO_DEPTH];
  logic [ADDR_BITS-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;

  logic [PTR_W:0]         fifo_count_s;
  logic                   fifo_empty_s;
  logic                   fifo_full_s;
  logic                   accept_s;
  logic                   last_byte_s;
  logic                   push_s;
  logic                   pop_s;
  logic [31:0]            push_data_s;
  logic [3:0]             push_strb_s;
  logic [ADDR_BITS-1:0]   push_addr_s;

  assign fifo_count_s = wr_ptr_q - rd_ptr_q;
  assign fifo_empty_s = (fifo_count_s == '0);
  assign fifo_full_s  = (fifo_count_s == FULL_CNT);

  // in_ready depends only on registered state, never on glb_wready.
  assign in_ready    = (state_q == ST_RUN) && !fifo_full_s;
  assign accept_s    = i_en && in_ready;
  assign last_byte_s = (byte_cnt_q == (num_q - 16'd1));
  assign push_s      = accept_s && ((lane_q == 2'd3) || last_byte_s);
  assign push_data_s = {8'd0, pack_q} | (32'(data_in) << {lane_q, 3'b000});
  assign push_strb_s = lane_strb(lane_q);
  assign push_addr_s = word_addr(base_q, word_cnt_q);

  assign glb_wvalid = !fifo_empty_s;
  assign pop_s      = glb_wvalid && glb_wready;

  // Head fields read as zero while the FIFO is empty.
  assign glb_wdata = glb_wvalid ? fifo_data_q[rd_ptr_q[PTR_W-1:0]] : 32'd0;
  assign glb_wstrb = glb_wvalid ? fifo_strb_q[rd_ptr_q[PTR_W-1:0]] : 4'd0;
  assign glb_waddr = glb_wvalid ? fifo_addr_q[rd_ptr_q[PTR_W-1:0]] : '0;

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;

  // FIFO pointer update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ONE_CNT;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ONE_CNT;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Control FSM: transfer setup, byte packing, drain and completion.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          num_d      = num_bytes;
          byte_cnt_d = 16'd0;
          word_cnt_d = 16'd0;
          lane_d     = 2'd0;
          pack_d     = 24'd0;
          overflow_d = 1'b0;
          if (num_bytes == 16'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (i_en && !in_ready) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
        if (accept_s) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (push_s) begin
            pack_d     = 24'd0;
            lane_d     = 2'd0;
            word_cnt_d = word_cnt_q + 16'd1;
          end else begin
            pack_d = push_data_s[23:0];
            lane_d = lane_q + 2'd1;
          end
          if (last_byte_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DRAIN: begin
        // Finishing on the last pop makes done/idle land one cycle after it.
        if (fifo_empty_s || ((fifo_count_s == ONE_CNT) && pop_s)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= 16'd0;
      byte_cnt_q <= 16'd0;
      word_cnt_q <= 16'd0;
      lane_q     <= 2'd0;
      pack_q     <= 24'd0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= push_data_s;
      fifo_strb_q[wr_ptr_q[PTR_W-1:0]] <= push_strb_s;
      fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= push_addr_s;
    end
  end

endmodule

// File: tb/tb_ppu_packer.sv
// Directed, scoreboard-based bench for ppu_packer with default parameters.
module tb_ppu_packer;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] num_bytes = 16'd0;
  logic        i_en = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        glb_wready = 1'b0;
  logic        in_ready;
  logic        glb_wvalid;
  logic [15:0] glb_waddr;
  logic [31:0] glb_wdata;
  logic [3:0]  glb_wstrb;
  logic        busy;
  logic        done;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int last_hs_n = -100;
  int first_hs_n = -1;
  wr_t exp_q[$];
  logic [7:0] bb[$];

  ppu_packer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
    .i_en(i_en), .data_in(data_in), .in_ready(in_ready), .glb_wvalid(glb_wvalid),
    .glb_wready(glb_wready), .glb_waddr(glb_waddr), .glb_wdata(glb_wdata),
    .glb_wstrb(glb_wstrb), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.strb = s;
    exp_q.push_back(w);
  endtask

  // Expected words for the byte list in bb, little-endian, 4 bytes per word.
  task automatic build_exp(input logic [15:0] base);
    logic [31:0] w;
    logic [3:0]  s;
    w = 32'd0;
    s = 4'd0;
    for (int i = 0; i < bb.size(); i++) begin
      w[8*(i%4) +: 8] = bb[i];
      s[i%4] = 1'b1;
      if ((i % 4 == 3) || (i == bb.size() - 1)) begin
        push_exp(base + 16'(4 * (i / 4)), w, s);
        w = 32'd0;
        s = 4'd0;
      end
    end
  endtask

  // One clock: check any handshake at the falling edge, return 1 after the rising edge.
  task automatic cyc();
    wr_t e;
    @(negedge clk);
    if (glb_wvalid && glb_wready) begin
      last_hs_n = cyc_n;
      if (first_hs_n < 0) first_hs_n = cyc_n;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", 32'(glb_waddr), 32'(e.addr));
        chk("wdata", glb_wdata, e.data);
        chk("wstrb", 32'(glb_wstrb), 32'(e.strb));
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic start_xfer(input logic [15:0] base, input logic [15:0] n);
    base_addr = base;
    num_bytes = n;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_bytes();
    for (int i = 0; i < bb.size(); i++) begin
      i_en = 1'b1;
      data_in = bb[i];
      cyc();
    end
    i_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      if (done) break;
      cyc();
    end
    if (k == 60) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_done_latency"}, 32'(cyc_n - last_hs_n), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
      cyc();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  // 24-byte transfer with the GLB stalled until the FIFO fills.
  task automatic stall_xfer(input logic [15:0] base, input bit held);
    int idx;
    glb_wready = 1'b0;
    bb.delete();
    for (int i = 0; i < 24; i++) bb.push_back(8'(8'h40 + i));
    build_exp(base);
    start_xfer(base, 16'd24);
    for (int i = 0; i < (held ? 20 : 16); i++) begin
      chk("stall_in_ready", 32'(in_ready), (i < 16) ? 32'd1 : 32'd0);
      i_en = 1'b1;
      data_in = (i < 16) ? bb[i] : 8'hEE;
      cyc();
    end
    i_en = 1'b0;
    repeat (2) cyc();
    chk("stall_full_in_ready", 32'(in_ready), 32'd0);
    chk("stall_wvalid", 32'(glb_wvalid), 32'd1);
    chk("stall_overflow", 32'(overflow), 32'(held));
    glb_wready = 1'b1;
    idx = 16;
    for (int k = 0; k < 100 && idx < 24; k++) begin
      if (in_ready) begin
        i_en = 1'b1;
        data_in = bb[idx];
        idx++;
      end else begin
        i_en = 1'b0;
      end
      cyc();
    end
    i_en = 1'b0;
    chk("stall_feed_complete", 32'(idx), 32'd24);
    wait_done("stall");
    chk("stall_overflow_sticky", 32'(overflow), 32'(held));
  endtask

  initial begin
    #2 rst = 1'b0;
    cyc();
    cyc();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wvalid", 32'(glb_wvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_waddr", 32'(glb_waddr), 32'd0);
    chk("rst_wdata", glb_wdata, 32'd0);
    chk("rst_wstrb", 32'(glb_wstrb), 32'd0);
    rst = 1'b1;
    cyc();

    // Two full words, GLB always ready.
    glb_wready = 1'b1;
    push_exp(16'h0100, 32'h44332211, 4'hF);
    push_exp(16'h0104, 32'h88776655, 4'hF);
    start_xfer(16'h0100, 16'd8);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    first_hs_n = -1;
    for (int i = 0; i < 8; i++) begin
      int acc_n;
      chk("run_in_ready", 32'(in_ready), 32'd1);
      i_en = 1'b1;
      data_in = 8'(8'h11 * (i + 1));
      acc_n = cyc_n;
      cyc();
      if (i == 3) begin
        i_en = 1'b0;
        cyc();
        chk("first_wvalid_latency", 32'(first_hs_n - acc_n), 32'd1);
      end
    end
    i_en = 1'b0;
    wait_done("full");

    // Partial last word; a start while busy must be ignored.
    push_exp(16'h0200, 32'h44332211, 4'hF);
    push_exp(16'h0204, 32'h00006655, 4'b0011);
    start_xfer(16'h0200, 16'd6);
    for (int i = 0; i < 6; i++) begin
      i_en = 1'b1;
      data_in = 8'(8'h11 * (i + 1));
      if (i == 2) begin
        start = 1'b1;
        base_addr = 16'h3333;
        num_bytes = 16'd2;
      end
      cyc();
      start = 1'b0;
    end
    i_en = 1'b0;
    wait_done("partial");

    // Address wrap at the top of the address space.
    push_exp(16'hFFFC, 32'hA3A2A1A0, 4'hF);
    push_exp(16'h0000, 32'hA7A6A5A4, 4'hF);
    bb.delete();
    for (int i = 0; i < 8; i++) bb.push_back(8'(8'hA0 + i));
    start_xfer(16'hFFFC, 16'd8);
    send_bytes();
    wait_done("wrap");

    // Back-pressure with a well-behaved producer, then with one that ignores in_ready.
    stall_xfer(16'h2000, 1'b0);
    stall_xfer(16'h1000, 1'b1);

    // Zero-length transfer also clears the sticky overflow.
    start_xfer(16'h0800, 16'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_wvalid", 32'(glb_wvalid), 32'd0);
    chk("zero_overflow_cleared", 32'(overflow), 32'd0);
    cyc();
    chk("zero_done_pulse", 32'(done), 32'd0);

    // Bytes offered while idle are ignored.
    i_en = 1'b1;
    data_in = 8'h5A;
    repeat (2) cyc();
    i_en = 1'b0;
    chk("idle_ien_overflow", 32'(overflow), 32'd0);
    chk("idle_ien_wvalid", 32'(glb_wvalid), 32'd0);

    // Asynchronous reset mid-transfer with a word queued.
    glb_wready = 1'b0;
    bb.delete();
    for (int i = 0; i < 5; i++) bb.push_back(8'(8'h51 + i));
    start_xfer(16'h0400, 16'd12);
    send_bytes();
    chk("prerst_wvalid", 32'(glb_wvalid), 32'd1);
    chk("prerst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_wvalid", 32'(glb_wvalid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("postrst_wvalid", 32'(glb_wvalid), 32'd0);

    // A clean transfer after the reset.
    glb_wready = 1'b1;
    bb.delete();
    for (int i = 0; i < 7; i++) bb.push_back(8'(8'hC0 + 3 * i));
    build_exp(16'h0500);
    start_xfer(16'h0500, 16'd7);
    send_bytes();
    wait_done("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
